// File: rtl/prog_clk_divider_pkg.sv
// Shared definitions for the programmable clock divider: divisor clamping,
// high-phase length and the per-channel state encoding.
// Build option: CLKDIV_SYNC_EN (adds the sync_pulse phase-align input on the top).
package clkdiv_pkg;

    localparam int CNT_W_DEFAULT = 16;
    localparam int MIN_DIV       = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } ch_state_e;

    // Divisors below MIN_DIV cannot form a high and a low phase, so they are clamped
    function automatic logic [31:0] eff_div(input logic [31:0] d);
        return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
    endfunction

    // ceil(D/2): odd divisors put the extra cycle in the high phase
    function automatic logic [31:0] high_len(input logic [31:0] d);
        return (eff_div(d) + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Control/status bundle for prog_clk_divider: divisor write port, run requests
// and the per-channel divided clock, tick and running outputs.
// Build option: CLKDIV_SYNC_EN (sync_pulse is a plain top-level port, not part of this bundle).
interface prog_clk_divider_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              div_we;
    logic [SEL_W-1:0]  div_sel;
    logic [CNT_W-1:0]  div_data;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] O_CLK;
    logic [NUM_CH-1:0] O_TICK;
    logic [NUM_CH-1:0] O_RUN;

    modport master (
        output div_we, div_sel, div_data, ch_en,
        input  O_CLK, O_TICK, O_RUN
    );

    modport slave (
        input  div_we, div_sel, div_data, ch_en,
        output O_CLK, O_TICK, O_RUN
    );
endinterface

// File: rtl/prog_clk_divider_channel.sv
// One divider channel: period counter, shadow divisor register and run FSM.
// O_CLK/O_TICK are registered from the next-state counter so they never come
// straight off a comparator.
// Build option: CLKDIV_SYNC_EN (when undefined the top ties sync_pulse low).
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | stopped, cnt held at 0, outputs low, pending divisor applied
//   RUN      | counting periods, ch_en high
//   STOPPING | ch_en low, finishing current period, goes IDLE at the wrap
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = 20
) (
    input  logic             I_CLK,
    input  logic             Rst,
    input  logic             ch_en,
    input  logic             sync_pulse,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_data,
    output logic             o_clk,
    output logic             o_tick,
    output logic             o_run
);

    localparam logic [1:0] ST_IDLE     = IDLE;
    localparam logic [1:0] ST_RUN      = RUN;
    localparam logic [1:0] ST_STOPPING = STOPPING;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cur_div, div_nxt;
    logic [CNT_W-1:0] pend_div;
    logic             pend_valid;
    logic             clk_nxt, tick_nxt;
    logic             is_idle, wrap, sync_hit, apply;
    logic [31:0]      d_cur, d_nxt, h_nxt;

    // Next-state, divisor-apply and next-output decode
    always_comb begin
        is_idle   = (state == ST_IDLE);
        d_cur     = eff_div(32'(cur_div));
        wrap      = !is_idle && (32'(cnt) == d_cur - 32'd1);
        sync_hit  = sync_pulse && !is_idle;
        apply     = pend_valid && (is_idle || wrap || sync_hit);
        div_nxt   = apply ? pend_div : cur_div;
        d_nxt     = eff_div(32'(div_nxt));
        h_nxt     = high_len(32'(div_nxt));

        state_nxt = state;
        cnt_nxt   = '0;
        clk_nxt   = 1'b0;
        tick_nxt  = 1'b0;

        if (is_idle) begin
            if (ch_en) begin
                state_nxt = ST_RUN;
                clk_nxt   = 1'b1;
            end
        end else if (wrap && !ch_en) begin
            // Stopping wins over a simultaneous sync so the period is not restarted
            state_nxt = ST_IDLE;
        end else begin
            state_nxt = ch_en ? ST_RUN : ST_STOPPING;
            cnt_nxt   = (wrap || sync_hit) ? '0 : cnt + CNT_W'(1);
            clk_nxt   = 32'(cnt_nxt) < h_nxt;
            tick_nxt  = 32'(cnt_nxt) == d_nxt - 32'd1;
        end
    end

    // Channel registers, synchronous reset
    always_ff @(posedge I_CLK) begin
        if (Rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            cur_div    <= CNT_W'(DEFAULT_DIV);
            pend_div   <= CNT_W'(DEFAULT_DIV);
            pend_valid <= 1'b0;
            o_clk      <= 1'b0;
            o_tick     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cur_div <= div_nxt;
            o_clk   <= clk_nxt;
            o_tick  <= tick_nxt;
            // A write on the apply edge lands in the shadow for the next period
            if (wr_en) begin
                pend_div   <= wr_data;
                pend_valid <= 1'b1;
            end else if (apply) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign o_run = (state != ST_IDLE);

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel runtime-programmable clock divider. Decodes divisor writes to
// one channel and instantiates NUM_CH independent clkdiv_channel blocks.
// Build option: CLKDIV_SYNC_EN adds sync_pulse, which restarts every running
// channel at cnt=0 on the same edge.
module prog_clk_divider
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = 20
) (
    input  logic I_CLK,
    input  logic Rst,
`ifdef CLKDIV_SYNC_EN
    input  logic sync_pulse,
`endif
    prog_clk_divider_if.slave bus
);

    logic              sync_i;
    logic [NUM_CH-1:0] ch_we;
    logic [NUM_CH-1:0] clk_v, tick_v, run_v;

`ifdef CLKDIV_SYNC_EN
    assign sync_i = sync_pulse;
`else
    assign sync_i = 1'b0;
`endif

    // One-hot write decode; out-of-range channel selects are dropped
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.div_we && (32'(bus.div_sel) == 32'(i))) begin
                ch_we[i] = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .I_CLK      (I_CLK),
            .Rst        (Rst),
            .ch_en      (bus.ch_en[i]),
            .sync_pulse (sync_i),
            .wr_en      (ch_we[i]),
            .wr_data    (bus.div_data),
            .o_clk      (clk_v[i]),
            .o_tick     (tick_v[i]),
            .o_run      (run_v[i])
        );
    end

    assign bus.O_CLK  = clk_v;
    assign bus.O_TICK = tick_v;
    assign bus.O_RUN  = run_v;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Self-checking bench for prog_clk_divider: directed period/stop/reset
// scenarios plus a randomized phase, all checked against a period-position
// reference model. Build option: CLKDIV_SYNC_EN enables the sync scenario.
module tb_prog_clk_divider;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int DEF    = 20;

    logic I_CLK = 1'b0;
    logic Rst;
    logic sync_pulse;

    int vecs = 0;
    int errs = 0;

    // Reference model: per channel, running flag, position within the period,
    // active divisor and shadow divisor
    int m_run [NUM_CH];
    int m_pos [NUM_CH];
    int m_div [NUM_CH];
    int m_pend[NUM_CH];
    int m_pv  [NUM_CH];

    prog_clk_divider_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    prog_clk_divider #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .I_CLK      (I_CLK),
        .Rst        (Rst),
`ifdef CLKDIV_SYNC_EN
        .sync_pulse (sync_pulse),
`endif
        .bus        (bus)
    );

    always #5 I_CLK = ~I_CLK;

    function automatic int per(int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic take(int c);
        if (m_pv[c] != 0) begin
            m_div[c] = m_pend[c];
            m_pv[c]  = 0;
        end
    endtask

    task automatic model_edge();
        bit sy;
        sy = 1'b0;
`ifdef CLKDIV_SYNC_EN
        sy = sync_pulse;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            if (Rst) begin
                m_run[c] = 0; m_pos[c] = 0; m_div[c] = DEF; m_pend[c] = DEF; m_pv[c] = 0;
            end else begin
                int p;
                p = per(m_div[c]);
                if (m_run[c] == 0) begin
                    take(c);
                    if (bus.ch_en[c]) begin
                        m_run[c] = 1;
                        m_pos[c] = 0;
                    end
                end else if (m_pos[c] == p - 1 && !bus.ch_en[c]) begin
                    m_run[c] = 0;
                    m_pos[c] = 0;
                    take(c);
                end else if (sy || m_pos[c] == p - 1) begin
                    m_pos[c] = 0;
                    take(c);
                end else begin
                    m_pos[c]++;
                end
                if (bus.div_we && int'(bus.div_sel) == c) begin
                    m_pend[c] = int'(bus.div_data);
                    m_pv[c]   = 1;
                end
            end
        end
    endtask

    task automatic check_outs();
        logic [NUM_CH-1:0] e_clk, e_tick, e_run;
        for (int c = 0; c < NUM_CH; c++) begin
            int p;
            p = per(m_div[c]);
            e_run[c]  = (m_run[c] != 0);
            e_clk[c]  = (m_run[c] != 0) && (m_pos[c] < (p + 1) / 2);
            e_tick[c] = (m_run[c] != 0) && (m_pos[c] == p - 1);
        end
        chk("o_clk",  32'(bus.O_CLK),  32'(e_clk));
        chk("o_tick", 32'(bus.O_TICK), 32'(e_tick));
        chk("o_run",  32'(bus.O_RUN),  32'(e_run));
    endtask

    task automatic cycle();
        @(posedge I_CLK);
        model_edge();
        #1;
        check_outs();
    endtask

    task automatic wait_pos(int c, int p);
        int g;
        g = 0;
        while (m_pos[c] != p && g < 200) begin
            cycle();
            g++;
        end
        if (g >= 200) begin
            errs++;
            $error("FAIL wait_pos ch%0d observed=%0d expected=%0d", c, m_pos[c], p);
        end
    endtask

    task automatic cycles_to_tick(int c, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!bus.O_TICK[c] && n < 200);
    endtask

    task automatic write_div(int c, int d);
        bus.div_we   = 1'b1;
        bus.div_sel  = 2'(c);
        bus.div_data = 16'(d);
        cycle();
        bus.div_we   = 1'b0;
    endtask

    initial begin
        int hi, tk, n;

        Rst          = 1'b1;
        sync_pulse   = 1'b0;
        bus.div_we   = 1'b0;
        bus.div_sel  = '0;
        bus.div_data = '0;
        bus.ch_en    = '0;
        cycle();
        cycle();
        chk("rst_clk",  32'(bus.O_CLK),  0);
        chk("rst_tick", 32'(bus.O_TICK), 0);
        chk("rst_run",  32'(bus.O_RUN),  0);
        Rst = 1'b0;

        // Default divisor 20 on ch0: 10 high / 10 low, one tick per 20 cycles
        bus.ch_en[0] = 1'b1;
        cycle();
        hi = 0; tk = 0;
        for (int k = 0; k < 40; k++) begin
            hi += int'(bus.O_CLK[0]);
            tk += int'(bus.O_TICK[0]);
            cycle();
        end
        chk("d20_high", hi, 20);
        chk("d20_tick", tk, 2);

        // D=5 on ch1 written while idle: 3 high / 2 low
        write_div(1, 5);
        cycle();
        bus.ch_en[1] = 1'b1;
        cycle();
        hi = 0; tk = 0;
        for (int k = 0; k < 10; k++) begin
            hi += int'(bus.O_CLK[1]);
            tk += int'(bus.O_TICK[1]);
            cycle();
        end
        chk("d5_high", hi, 6);
        chk("d5_tick", tk, 2);

        // D=0 clamps to 2 after the next wrap
        write_div(1, 0);
        cycles_to_tick(1, n);
        cycle();
        hi = 0; tk = 0;
        for (int k = 0; k < 10; k++) begin
            hi += int'(bus.O_CLK[1]);
            tk += int'(bus.O_TICK[1]);
            cycle();
        end
        chk("d0_high", hi, 5);
        chk("d0_tick", tk, 5);

        // Mid-period write on ch0 at cnt=7: current 20-cycle period completes
        wait_pos(0, 7);
        write_div(0, 8);
        cycles_to_tick(0, n);
        chk("mid_wr_rest", n, 11);
        cycles_to_tick(0, n);
        chk("mid_wr_new", n, 8);

        // Write coincident with the wrap on ch3: one more 20-cycle period
        bus.ch_en[3] = 1'b1;
        cycle();
        wait_pos(3, 19);
        write_div(3, 8);
        cycles_to_tick(3, n);
        chk("wrap_wr_old", n, 19);
        cycles_to_tick(3, n);
        chk("wrap_wr_new", n, 8);

        // Graceful stop on ch2 (D=10) dropped at cnt=3
        write_div(2, 10);
        bus.ch_en[2] = 1'b1;
        cycle();
        wait_pos(2, 3);
        bus.ch_en[2] = 1'b0;
        cycles_to_tick(2, n);
        chk("stop_rest", n, 6);
        cycle();
        chk("stop_run", 32'(bus.O_RUN[2]), 0);
        chk("stop_clk", 32'(bus.O_CLK[2]), 0);

        // Re-assert during STOPPING: no gap between periods
        bus.ch_en[2] = 1'b1;
        cycle();
        wait_pos(2, 3);
        bus.ch_en[2] = 1'b0;
        wait_pos(2, 5);
        bus.ch_en[2] = 1'b1;
        cycles_to_tick(2, n);
        chk("resume_rest", n, 4);
        cycle();
        chk("resume_run", 32'(bus.O_RUN[2]), 1);
        cycles_to_tick(2, n);
        chk("resume_next", n, 9);

        // Reset at cnt=12 with a pending write: pending is lost, D back to 20
        bus.ch_en = '0;
        Rst = 1'b1;
        cycle();
        Rst = 1'b0;
        bus.ch_en = 4'b0001;
        cycle();
        wait_pos(0, 11);
        write_div(0, 8);
        Rst = 1'b1;
        cycle();
        chk("rst_mid_clk", 32'(bus.O_CLK), 0);
        chk("rst_mid_run", 32'(bus.O_RUN), 0);
        Rst = 1'b0;
        cycle();
        cycles_to_tick(0, n);
        chk("rst_mid_div", n, 19);

        // Randomized writes and run requests against the model
        for (int k = 0; k < 400; k++) begin
            bus.div_we   = ($urandom_range(0, 3) == 0);
            bus.div_sel  = 2'($urandom_range(0, NUM_CH - 1));
            bus.div_data = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) bus.ch_en = 4'($urandom);
`ifdef CLKDIV_SYNC_EN
            sync_pulse = ($urandom_range(0, 24) == 0);
`endif
            cycle();
        end
        bus.div_we = 1'b0;
        sync_pulse = 1'b0;

`ifdef CLKDIV_SYNC_EN
        // Phase-align ch0 (D=6) and ch1 (D=9)
        bus.ch_en = '0;
        Rst = 1'b1;
        cycle();
        Rst = 1'b0;
        write_div(0, 6);
        write_div(1, 9);
        bus.ch_en = 4'b0001;
        cycle();
        cycle();
        bus.ch_en = 4'b0011;
        repeat (7) cycle();
        sync_pulse = 1'b1;
        cycle();
        sync_pulse = 1'b0;
        chk("sync_clk", 32'(bus.O_CLK[1:0]), 3);
        cycles_to_tick(0, n);
        chk("sync_ch0_tick", n, 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
